// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch buffer feeding the IF/ID register.
// Rev 1.0 - sequential fetch, DEPTH-entry {pc, instr} queue, redirect flush.
`default_nettype none

module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     deq_ready,
  output logic                     deq_valid,
  output logic [31:0]              deq_pc,
  output logic [31:0]              deq_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  // Word addresses only: the two byte-offset bits are implicitly zero.
  logic [31:2]   fetch_pc;
  logic [31:2]   inflight_pc;
  logic          inflight;
  logic [AW-1:0] head;
  logic [AW-1:0] tail;

  logic [31:2]   mem_pc    [DEPTH];
  logic [31:0]   mem_instr [DEPTH];

  logic [CW:0]   credit;
  logic          fire;
  logic          unused_bits;

  assign unused_bits = ^redirect_pc[1:0];

  // Credit counts the in-flight slot so the returning response always fits.
  assign credit    = {1'b0, count} + {{CW{1'b0}}, inflight};
  assign imem_req  = reset && !redirect && (credit < (CW+1)'(DEPTH));
  assign imem_addr = {fetch_pc, 2'b00};

  assign deq_valid = (count != '0) && !redirect;
  assign deq_pc    = (count != '0) ? {mem_pc[head], 2'b00} : 32'h0;
  assign deq_instr = (count != '0) ? mem_instr[head] : 32'h0;
  assign fire      = deq_valid && deq_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc    <= RESET_PC[31:2];
      inflight_pc <= '0;
      inflight    <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else if (redirect) begin
      fetch_pc    <= redirect_pc[31:2];
      inflight    <= 1'b0;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
    end else begin
      if (inflight) begin
        tail <= tail + 1'b1;
      end
      if (fire) begin
        head <= head + 1'b1;
      end
      count    <= count + CW'(inflight) - CW'(fire);
      inflight <= imem_req;
      if (imem_req) begin
        inflight_pc <= fetch_pc;
        fetch_pc    <= fetch_pc + 1'b1;
      end
    end
  end

  // Storage needs no reset: entries are only visible while count is non-zero.
  always_ff @(posedge clk) begin
    if (inflight && !redirect) begin
      mem_pc[tail]    <= inflight_pc;
      mem_instr[tail] <= imem_rdata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: queue-based reference model with random and directed stimulus.
`default_nettype none

module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH) + 1;
  localparam logic [31:0] XORK = 32'hA5A5_0000;

  logic          clk;
  logic          reset;
  logic          imem_req;
  logic [31:0]   imem_addr;
  logic [31:0]   imem_rdata;
  logic          redirect;
  logic [31:0]   redirect_pc;
  logic          deq_ready;
  logic          deq_valid;
  logic [31:0]   deq_pc;
  logic [31:0]   deq_instr;
  logic [CW-1:0] count;

  logic          reset2;
  logic          imem_req2;
  logic [31:0]   imem_addr2;
  logic [31:0]   imem_rdata2;
  logic          redirect2;
  logic [31:0]   redirect_pc2;
  logic          deq_ready2;
  logic          deq_valid2;
  logic [31:0]   deq_pc2;
  logic [31:0]   deq_instr2;
  logic [CW-1:0] count2;

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) u_dut (
    .clk(clk), .reset(reset), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect(redirect), .redirect_pc(redirect_pc),
    .deq_ready(deq_ready), .deq_valid(deq_valid), .deq_pc(deq_pc),
    .deq_instr(deq_instr), .count(count)
  );

  fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'hFFFF_FFF8)) u_dut_wrap (
    .clk(clk), .reset(reset2), .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect(redirect2), .redirect_pc(redirect_pc2),
    .deq_ready(deq_ready2), .deq_valid(deq_valid2), .deq_pc(deq_pc2),
    .deq_instr(deq_instr2), .count(count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: a plain queue of buffered entries plus one pending request.
  logic [31:0] qpc[$];
  logic [31:0] qins[$];
  logic        m_inf;
  logic [31:0] m_inf_pc;
  logic [31:0] m_pc;

  logic        prev_req;
  logic [31:0] prev_addr;

  logic          s_req;
  logic [31:0]   s_addr;
  logic          s_valid;
  logic [31:0]   s_pc;
  logic [CW-1:0] s_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    qpc.delete();
    qins.delete();
    m_inf    = 1'b0;
    m_inf_pc = 32'h0;
    m_pc     = 32'h0;
    prev_req = 1'b0;
    prev_addr = 32'h0;
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic cycle(input logic rd, input logic [31:0] rpc, input logic dr);
    logic        e_req;
    logic        e_valid;
    logic [31:0] e_pc;
    logic [31:0] e_ins;
    redirect    = rd;
    redirect_pc = rpc;
    deq_ready   = dr;
    imem_rdata  = prev_req ? (prev_addr ^ XORK) : $urandom;
    #1;
    e_req   = !rd && ((qpc.size() + int'(m_inf)) < DEPTH);
    e_valid = (qpc.size() != 0) && !rd;
    e_pc    = (qpc.size() != 0) ? qpc[0]  : 32'h0;
    e_ins   = (qpc.size() != 0) ? qins[0] : 32'h0;
    chk("imem_req",  imem_req,  e_req);
    chk("imem_addr", imem_addr, m_pc);
    chk("deq_valid", deq_valid, e_valid);
    chk("deq_pc",    deq_pc,    e_pc);
    chk("deq_instr", deq_instr, e_ins);
    chk("count",     count,     qpc.size());
    s_req = imem_req; s_addr = imem_addr; s_valid = deq_valid; s_pc = deq_pc; s_cnt = count;
    prev_req  = imem_req;
    prev_addr = imem_addr;
    @(posedge clk);
    if (rd) begin
      qpc.delete();
      qins.delete();
      m_inf = 1'b0;
      m_pc  = {rpc[31:2], 2'b00};
    end else begin
      if (e_valid && dr) begin
        void'(qpc.pop_front());
        void'(qins.pop_front());
      end
      if (m_inf) begin
        qpc.push_back(m_inf_pc);
        qins.push_back(imem_rdata);
      end
      m_inf = e_req;
      if (e_req) begin
        m_inf_pc = m_pc;
        m_pc     = m_pc + 32'd4;
      end
    end
    @(negedge clk);
  endtask

  // Hold reset across a few edges and release at a falling edge.
  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_req",   imem_req,  32'h0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", deq_valid, 32'h0);
    chk("rst_pc",    deq_pc,    32'h0);
    chk("rst_instr", deq_instr, 32'h0);
    chk("rst_count", count,     32'h0);
    model_reset();
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  logic [31:0] wrap_addr [4];
  int          max_cnt;

  initial begin
    reset = 1'b0; redirect = 1'b0; redirect_pc = 32'h0; deq_ready = 1'b0; imem_rdata = 32'h0;
    reset2 = 1'b0; redirect2 = 1'b0; redirect_pc2 = 32'h0; deq_ready2 = 1'b1; imem_rdata2 = 32'h0;
    model_reset();

    // Free-running fetch with an always-ready consumer.
    do_reset();
    max_cnt = 0;
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (k == 0) chk("t1_first_req_addr", s_addr, 32'h0);
      if (k == 1) chk("t1_no_early_valid", s_valid, 32'h0);
      if (k == 2) begin
        chk("t1_first_valid", s_valid, 32'h1);
        chk("t1_first_pc", s_pc, 32'h0);
      end
      if (int'(s_cnt) > max_cnt) max_cnt = int'(s_cnt);
    end
    chk("t1_count_le2", 32'(max_cnt <= 2), 32'h1);

    // Stalled consumer fills the queue, then drains in order.
    do_reset();
    repeat (8) cycle(1'b0, 32'h0, 1'b0);
    #1;
    chk("t2_full_count", count, 32'd4);
    chk("t2_full_req", imem_req, 32'h0);
    chk("t2_full_addr", imem_addr, 32'h10);
    for (int k = 0; k < 8; k++) begin
      cycle(1'b0, 32'h0, 1'b1);
      if (k < 4) chk("t2_drain_pc", s_pc, 32'(4 * k));
      if (k == 1) begin
        chk("t2_resume_req", s_req, 32'h1);
        chk("t2_resume_addr", s_addr, 32'h10);
      end
    end

    // Redirect with two entries buffered and the 0x8 fetch in flight.
    do_reset();
    repeat (3) cycle(1'b0, 32'h0, 1'b0);
    cycle(1'b1, 32'h40, 1'b1);
    chk("t3_count_before", s_cnt, 32'd2);
    chk("t3_valid_on_redirect", s_valid, 32'h0);
    chk("t3_req_on_redirect", s_req, 32'h0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t3_count_after", s_cnt, 32'h0);
    chk("t3_new_addr", s_addr, 32'h40);
    cycle(1'b0, 32'h0, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t3_first_pc", s_pc, 32'h40);

    // Unaligned redirect target and back-to-back redirects.
    cycle(1'b1, 32'h43, 1'b1);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t4_aligned_addr", s_addr, 32'h40);
    cycle(1'b1, 32'h100, 1'b1);
    cycle(1'b1, 32'h200, 1'b0);
    cycle(1'b0, 32'h0, 1'b1);
    chk("t4_last_redirect_wins", s_addr, 32'h200);
    repeat (6) cycle(1'b0, 32'h0, 1'b1);

    // Asynchronous reset with three entries buffered and one fetch in flight.
    do_reset();
    repeat (4) cycle(1'b0, 32'h0, 1'b0);
    #1;
    chk("t6_count_pre", count, 32'd3);
    #2;
    reset = 1'b0;
    #1;
    chk("t6_req",   imem_req,  32'h0);
    chk("t6_addr",  imem_addr, 32'h0);
    chk("t6_valid", deq_valid, 32'h0);
    chk("t6_pc",    deq_pc,    32'h0);
    chk("t6_instr", deq_instr, 32'h0);
    chk("t6_count", count,     32'h0);
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    cycle(1'b0, 32'h0, 1'b1);
    chk("t6_first_addr", s_addr, 32'h0);
    repeat (6) cycle(1'b0, 32'h0, 1'b1);

    // Random traffic: consumer stalls, redirects to random and wrapping targets.
    for (int k = 0; k < 3000; k++) begin
      logic        rd;
      logic [31:0] rpc;
      rd  = ($urandom_range(0, 19) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      cycle(rd, rpc, ($urandom_range(0, 9) < 6));
    end

    // Address wrap from a RESET_PC near the top of the address space.
    wrap_addr[0] = 32'hFFFF_FFF8;
    wrap_addr[1] = 32'hFFFF_FFFC;
    wrap_addr[2] = 32'h0000_0000;
    wrap_addr[3] = 32'h0000_0004;
    @(negedge clk);
    reset2 = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic        r2;
      logic [31:0] a2;
      #1;
      if (k < 4) begin
        chk("t5_req", imem_req2, 32'h1);
        chk("t5_addr", imem_addr2, wrap_addr[k]);
      end
      if (k >= 2) begin
        chk("t5_valid", deq_valid2, 32'h1);
        chk("t5_pc", deq_pc2, wrap_addr[k-2]);
        chk("t5_instr", deq_instr2, wrap_addr[k-2] ^ XORK);
      end
      r2 = imem_req2;
      a2 = imem_addr2;
      @(negedge clk);
      imem_rdata2 = r2 ? (a2 ^ XORK) : 32'h0;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
